// File: rtl/data_memory_pkg.sv
// Shared processor constants for the data memory: funct3 access encodings
// and helpers that classify an access by size and alignment.
package data_memory_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte addressing with Addr[1:0] fixes a word at four byte lanes.
    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic size_e load_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            F3_LW:         return SZ_WORD;
            default:       return SZ_NONE;
        endcase
    endfunction

    function automatic size_e store_size(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            F3_SW:   return SZ_WORD;
            default: return SZ_NONE;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] addr_lo);
        case (sz)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_store_align.sv
// Store lane steering: byte-lane enables and replicated write data so that
// every lane carries the value it would receive for its access size.
module store_align
    import data_memory_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [WIDTH-1:0]      wdata,
    output logic [BYTE_LANES-1:0] byte_en,
    output logic [WIDTH-1:0]      wdata_rep
);

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        byte_en   = '0;
        wdata_rep = '0;
        case (store_size(funct3))
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory with sized/sign-extended loads, lane stores and a
// sticky misaligned-access fault that records the first offending address.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] Addr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             Fault,
    output logic [WIDTH-1:0] FaultAddr
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  rd_mis;
    logic                  wr_mis;
    logic                  write_ok;
    logic [BYTE_LANES-1:0] byte_en;
    logic [WIDTH-1:0]      wdata_rep;
    logic [WIDTH-1:0]      word;
    logic [WIDTH-1:0]      shifted;

    // Address bits above the array wrap around by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[WIDTH-1:IDX_W+2];

    assign idx      = Addr[IDX_W+1:2];
    assign word     = mem[idx];
    assign rd_mis   = MemRead  && misaligned(load_size(funct3), Addr[1:0]);
    assign wr_mis   = MemWrite && misaligned(store_size(funct3), Addr[1:0]);
    assign write_ok = MemWrite && (store_size(funct3) != SZ_NONE) && !wr_mis;

    store_align #(.WIDTH(WIDTH)) u_store_align (
        .funct3    (funct3),
        .addr_lo   (Addr[1:0]),
        .wdata     (WriteData),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep)
    );

    // NOTE: the array has a reset because loads must read zero right after it;
    // that makes it flops, not an inferred RAM block.
    // NOTE: non-blocking assignments keep every register update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            Fault     <= 1'b0;
            FaultAddr <= '0;
        end else begin
            if (write_ok) begin
                for (int l = 0; l < BYTE_LANES; l++) begin
                    if (byte_en[l]) begin
                        mem[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
                    end
                end
            end
            if (!Fault && (rd_mis || wr_mis)) begin
                Fault     <= 1'b1;
                FaultAddr <= Addr;
            end
        end
    end

    // Shift the addressed lane down to bit 0; aligned halves land there too.
    assign shifted = word >> {Addr[1:0], 3'b000};

    always_comb begin
        ReadData = '0;
        if (MemRead && !rd_mis) begin
            case (funct3)
                F3_LB:   ReadData = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
                F3_LH:   ReadData = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
                F3_LW:   ReadData = word;
                F3_LBU:  ReadData = {{(WIDTH-8){1'b0}}, shifted[7:0]};
                F3_LHU:  ReadData = {{(WIDTH-16){1'b0}}, shifted[15:0]};
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed literal scenarios plus random
// traffic compared every cycle against a byte-level reference model.
module tb_data_memory;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             MemWrite;
    logic             MemRead;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] Addr;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ReadData;
    logic             Fault;
    logic [WIDTH-1:0] FaultAddr;

    int n_checks = 0;
    int n_errors = 0;

    data_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .funct3    (funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Fault     (Fault),
        .FaultAddr (FaultAddr)
    );

    always #5 clk = ~clk;

    // Reference model state: plain word array plus fault record.
    int unsigned mem_m [DEPTH];
    bit          fault_m;
    int unsigned faddr_m;
    bit          model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int load_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic int store_bytes(input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned exp_read(input bit re, input logic [2:0] f3,
                                             input int unsigned a);
        int n;
        int unsigned w, v;
        if (!re) return 0;
        n = load_bytes(f3);
        if (n == 0 || (a % n) != 0) return 0;
        w = mem_m[(a / 4) % DEPTH];
        if (n == 4) return w;
        v = w >> (8 * (a % 4));
        if (n == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Model update at the edge, from the inputs that were held across it.
    always @(posedge clk) begin
        int n_ld, n_st;
        bit mis;
        int unsigned a, w, sh;
        a = Addr;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
            fault_m     = 1'b0;
            faddr_m     = 0;
            model_valid = 1'b1;
        end else begin
            n_ld = load_bytes(funct3);
            n_st = store_bytes(funct3);
            mis  = (MemRead  && n_ld > 1 && (a % n_ld) != 0) ||
                   (MemWrite && n_st > 1 && (a % n_st) != 0);
            if (MemWrite && n_st > 0 && (a % n_st) == 0) begin
                w = mem_m[(a / 4) % DEPTH];
                for (int k = 0; k < n_st; k++) begin
                    sh = 8 * ((a % 4) + k);
                    w  = (w & ~(32'hFF << sh)) | (((WriteData >> (8 * k)) & 32'hFF) << sh);
                end
                mem_m[(a / 4) % DEPTH] = w;
            end
            if (mis && !fault_m) begin
                fault_m = 1'b1;
                faddr_m = a;
            end
        end
    end

    // Compare process: outputs checked mid-cycle against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("ReadData", ReadData, exp_read(MemRead, funct3, Addr));
            check("Fault", {31'd0, Fault}, {31'd0, fault_m});
            check("FaultAddr", FaultAddr, faddr_m);
        end
    end

    // Drive one cycle of inputs just after the edge, return mid-cycle.
    task automatic drive(input bit r, input bit we, input bit re, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst       = r;
        MemWrite  = we;
        MemRead   = re;
        funct3    = f3;
        Addr      = a;
        WriteData = wd;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        drive(1'b0, 1'b0, 1'b1, f3, a, 32'h0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        drive(1'b0, 1'b1, 1'b0, f3, a, wd);
    endtask

    initial begin
        int unsigned r;
        logic [2:0] f3r;
        rst = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
        funct3 = 3'd0; Addr = '0; WriteData = '0;
        repeat (2) @(posedge clk);

        // Reset state and post-reset loads.
        drive(1'b1, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        load(3'd2, 32'h0);  check("lw0_after_rst", ReadData, 32'h0);
        check("fault_after_rst", {31'd0, Fault}, 32'h0);
        load(3'd2, 32'h4);  check("lw4_after_rst", ReadData, 32'h0);
        load(3'd2, 32'hFC); check("lwFC_after_rst", ReadData, 32'h0);

        // Sized and sign-extended loads.
        store(3'd2, 32'h8, 32'h80F1_7F02);
        load(3'd0, 32'h8); check("lb_8", ReadData, 32'h0000_0002);
        load(3'd0, 32'hB); check("lb_B", ReadData, 32'hFFFF_FF80);
        load(3'd4, 32'hB); check("lbu_B", ReadData, 32'h0000_0080);
        load(3'd1, 32'hA); check("lh_A", ReadData, 32'hFFFF_80F1);
        load(3'd5, 32'h8); check("lhu_8", ReadData, 32'h0000_7F02);
        check("no_fault_aligned", {31'd0, Fault}, 32'h0);

        // Lane merging.
        store(3'd2, 32'h10, 32'h1122_3344);
        store(3'd0, 32'h11, 32'h0000_00AA);
        store(3'd1, 32'h12, 32'h0000_BEEF);
        load(3'd2, 32'h10); check("lw_merge", ReadData, 32'hBEEF_AA44);

        // Misaligned store: no write, fault captured once.
        store(3'd2, 32'h6, 32'hDEAD_BEEF);
        load(3'd2, 32'h4); check("mis_sw_w4", ReadData, 32'h0);
        check("fault_set", {31'd0, Fault}, 32'h1);
        check("faultaddr_6", FaultAddr, 32'h6);
        load(3'd2, 32'h8); check("mis_sw_w8", ReadData, 32'h80F1_7F02);
        load(3'd1, 32'h3); check("lh_mis_rd", ReadData, 32'h0);
        load(3'd2, 32'h8); check("faultaddr_kept", FaultAddr, 32'h6);

        // Address wrap.
        store(3'd2, 32'h104, 32'h5);
        load(3'd2, 32'h4); check("wrap_lw4", ReadData, 32'h5);

        // Reset beats a simultaneous store.
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 32'h1);
        load(3'd2, 32'h0); check("rst_over_sw", ReadData, 32'h0);
        check("rst_clear_fault", {31'd0, Fault}, 32'h0);

        // Read-during-write shows the old value.
        store(3'd2, 32'h20, 32'h1234_5678);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 32'h20, 32'hCAFE_BABE);
        check("rdw_old", ReadData, 32'h1234_5678);
        load(3'd2, 32'h20); check("rdw_new", ReadData, 32'hCAFE_BABE);

        // Random traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom;
            f3r = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 59) == 0), r[0], r[1], f3r,
                  (r[2] ? 32'($urandom) : 32'($urandom_range(0, 511))), 32'($urandom));
        end

        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 64, number of WIDTH-bit words (power of two).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 MemWrite  in  1  store enable from control unit.
REQ-006 MemRead  in  1  load qualifier from control unit.
REQ-007 funct3  in  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 Addr  in  WIDTH  byte address (ALUResult).
REQ-009 WriteData  in  WIDTH  store data (rs2); only the low bits relevant to the access size are used.
REQ-010 ReadData  out  WIDTH  load result, drives result-select input 01.
REQ-011 Fault  out  1  sticky misaligned-access flag.
REQ-012 FaultAddr  out  WIDTH  Addr of the first faulting access since reset.

Function
REQ-013 Word index SHALL be Addr[log2(DEPTH)+1:2]; upper address bits are ignored (aliasing wrap-around, no fault).
REQ-014 ReadData SHALL be combinational from the current array contents, Addr, funct3 and MemRead; zero latency.
REQ-015 When MemRead=0, ReadData SHALL be 0.
REQ-016 LB/LBU SHALL select the byte at Addr[1:0]; LH/LHU the half at Addr[1]; LW the full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-017 Any other funct3 with MemRead=1 SHALL give ReadData=0 and no fault.
REQ-018 Misaligned = (half access and Addr[0]=1) or (word access and Addr[1:0]!=00).
REQ-019 A misaligned load SHALL give ReadData=0.
REQ-020 Stores SHALL commit on the rising edge when MemWrite=1: SB writes one byte lane, SH two lanes, SW all four; other lanes unchanged.
REQ-021 A misaligned store or a store with funct3 not in {000,001,010} SHALL not modify the array.
REQ-022 MemRead=1 and MemWrite=1 in the same cycle SHALL be legal: ReadData shows pre-write contents; the write commits at the edge.
REQ-023 On the first misaligned access (MemRead or MemWrite high) with Fault=0, Fault SHALL be set and FaultAddr SHALL capture Addr at that edge; later faults SHALL not change FaultAddr.
REQ-024 Fault SHALL remain set until reset.

Reset
REQ-025 When rst=1 at a rising edge, every array word, Fault and FaultAddr SHALL become 0.
REQ-026 Reset SHALL override a simultaneous store or fault capture.
REQ-027 ReadData SHALL read 0 in the cycle after reset for any aligned load.

Structure
REQ-028 The funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) SHALL be named constants in the shared processor package.
REQ-029 Byte-lane enable and write-data replication SHALL be one sub-module, store_align (combinational), instantiated once.
REQ-030 Load extraction/extension and the storage array with the fault register SHALL reside in data_memory.

Verification
REQ-031 Reset, then LW from 0x0, 0x4 and 0xFC -> ReadData=0x00000000, Fault=0.
REQ-032 SW 0x8 <- 0x80F1_7F02, then LB 0x8=0x00000002, LB 0xB=0xFFFFFF80, LBU 0xB=0x00000080, LH 0xA=0xFFFF80F1, LHU 0x8=0x00007F02.
REQ-033 SW 0x10 <- 0x11223344, SB 0x11 <- 0xAA, SH 0x12 <- 0xBEEF -> LW 0x10=0xBEEFAA44.
REQ-034 SW 0x6 <- 0xDEADBEEF -> no word changed, Fault=1, FaultAddr=0x6; then LH 0x3 -> ReadData=0, FaultAddr stays 0x6.
REQ-035 SW 0x104 <- 0x5 with DEPTH=64 -> LW 0x4 returns 0x5 (wrap).
REQ-036 rst=1 and SW 0x0 <- 0x1 in the same cycle -> LW 0x0=0, Fault=0; simultaneous LW+SW 0x20 returns old value, new value on the next cycle.
